// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
//   master : stream source / system side (drives start and bytes, observes status)
//   slave  : the loader (accepts bytes, drives the imem write port and status)
interface imem_loader_if;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [31:0] addr_imem_ram_o;
  logic [31:0] wr_instr_imem_ram_o;
  logic        wr_en_imem_ram_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_written_o;

  modport master (
    output start_i, byte_i, byte_valid_i,
    input  byte_ready_o, addr_imem_ram_o, wr_instr_imem_ram_o, wr_en_imem_ram_o,
           busy_o, done_o, err_o, words_written_o
  );

  modport slave (
    input  start_i, byte_i, byte_valid_i,
    output byte_ready_o, addr_imem_ram_o, wr_instr_imem_ram_o, wr_en_imem_ram_o,
           busy_o, done_o, err_o, words_written_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream (16-bit LE word count, LE 32-bit
// words, XOR checksum over the data bytes) and writes each word into the
// instruction memory with a single-cycle strobe.
// Ports:
//   clk    rising-edge clock
//   rst_n  async active-low reset
//   bus    imem_loader_if.slave: start/byte stream in, imem write port and
//          busy/done/err/words_written status out
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  csum_q, csum_d;
  logic        rdy_q, rdy_d;
  logic        wen_q, wen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic [15:0] len_full;

  // ready is registered, so a transfer is judged against the flop value
  assign xfer     = bus.byte_valid_i & rdy_q;
  assign len_full = {bus.byte_i, count_q[7:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: if (bus.start_i) begin
        state_d = S_LEN0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        csum_d  = '0;
      end
      S_LEN0: if (xfer) begin
        count_d[7:0] = bus.byte_i;
        state_d      = S_LEN1;
      end
      S_LEN1: if (xfer) begin
        count_d[15:8] = bus.byte_i;
        bcnt_d        = '0;
        if ({1'b0, len_full} > MAX_CNT) state_d = S_ERR;
        else if (len_full == 16'd0)     state_d = S_CSUM;
        else                            state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        word_d[{bcnt_q, 3'b000} +: 8] = bus.byte_i;
        csum_d = csum_q ^ bus.byte_i;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          wdata_d = word_d;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        // 17-bit compare so idx+1 cannot wrap
        if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) state_d = S_DATA;
        else                                           state_d = S_CSUM;
      end
      S_CSUM: if (xfer) begin
        state_d = (bus.byte_i == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered: decode them from the next state
    rdy_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
             (state_d == S_DATA) || (state_d == S_CSUM);
    wen_d  = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    if (state_d == S_DONE) done_d = 1'b1;
    if (state_d == S_ERR)  err_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      rdy_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      rdy_q   <= rdy_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready_o        = rdy_q;
  assign bus.wr_en_imem_ram_o    = wen_q;
  assign bus.wr_instr_imem_ram_o = wdata_q;
  assign bus.addr_imem_ram_o     = BASE_ADDR + {16'd0, idx_q};
  assign bus.busy_o              = busy_q;
  assign bus.done_o              = done_q;
  assign bus.err_o               = err_q;
  assign bus.words_written_o     = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // observed writes and per-load cycle statistics
  logic [63:0] wr_q[$];
  int busy_cyc;
  int viol;

  always @(negedge clk) begin
    if (bus.wr_en_imem_ram_o) wr_q.push_back({bus.addr_imem_ram_o, bus.wr_instr_imem_ram_o});
    if (bus.busy_o) busy_cyc++;
    if (bus.wr_en_imem_ram_o && bus.byte_ready_o) viol++;
    // while loading, ready may only drop for a write (or the final DONE/ERR cycle)
    if (bus.busy_o && !bus.byte_ready_o && !bus.wr_en_imem_ram_o && !bus.done_o && !bus.err_o) viol++;
  end

  // reference model: frame bytes + expected writes from a word list
  logic [31:0] wq[$];
  logic [7:0]  stim_q[$];
  logic [63:0] exp_q[$];
  bit          exp_ok;

  function automatic void build(input logic [15:0] cnt, input bit corrupt);
    logic [7:0] cs = 8'h00;
    logic [31:0] w;
    stim_q = {};
    exp_q  = {};
    stim_q.push_back(cnt[7:0]);
    stim_q.push_back(cnt[15:8]);
    if (cnt > 16'd512) begin
      exp_ok = 1'b0;
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      w = wq[i];
      for (int k = 0; k < 4; k++) begin
        stim_q.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      exp_q.push_back({BASE + 32'(i), w});
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    stim_q.push_back(cs);
    exp_ok = !corrupt;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gmax, input bit pulses);
    int gaps;
    int t;
    bit r;
    bit fin;
    gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (gaps) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
      bus.byte_i       = 8'($urandom);
      bus.start_i      = pulses && bus.busy_o && ($urandom_range(0, 2) == 0);
      @(posedge clk);
    end
    t = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = b;
      r = bus.byte_ready_o;
      @(posedge clk);
      if (r) fin = 1'b1;
      else if (++t > 50) begin
        n_vec++; n_err++;
        $display("FAIL byte_accept_timeout byte=%h not accepted within 50 cycles", b);
        fin = 1'b1;
      end
    end
  endtask

  task automatic run_load(input int gmax, input bit pulses);
    int t;
    wr_q = {};
    busy_cyc = 0;
    viol = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    foreach (stim_q[i]) send_byte(stim_q[i], gmax, pulses);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.start_i      = 1'b0;
    t = 0;
    while (bus.busy_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy_o) begin
      n_vec++; n_err++;
      $display("FAIL load_end_timeout busy_o still 1 after 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.byte_ready_o, bus.wr_en_imem_ram_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b exp 00000",
        {bus.byte_ready_o, bus.wr_en_imem_ram_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    n_vec++;
    if (bus.addr_imem_ram_o !== BASE) begin
      n_err++; $display("FAIL reset_addr got %h exp %h", bus.addr_imem_ram_o, BASE);
    end
    n_vec++;
    if (bus.wr_instr_imem_ram_o !== 32'h0 || bus.words_written_o !== 16'h0) begin
      n_err++; $display("FAIL reset_data got %h/%0d exp 0/0", bus.wr_instr_imem_ram_o, bus.words_written_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal;
    wq = {32'h0050_0013, 32'h00A0_0093};
    build(16'd2, 1'b0);
    run_load(0, 1'b0);
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL normal_nwr got %0d exp %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (wr_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL normal_wr[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if ({bus.done_o, bus.err_o} !== 2'b10 || bus.words_written_o !== 16'd2) begin
      n_err++; $display("FAIL normal_status got done=%b err=%b ww=%0d exp 1/0/2",
        bus.done_o, bus.err_o, bus.words_written_o);
    end
    n_vec++;
    if (busy_cyc != 5*2 + 4) begin
      n_err++; $display("FAIL normal_cycles got %0d exp %0d", busy_cyc, 5*2 + 4);
    end
    n_vec++;
    if (viol != 0) begin
      n_err++; $display("FAIL normal_ready got %0d violations exp 0", viol);
    end
  endtask

  task automatic test_zero_len;
    wq = {};
    build(16'd0, 1'b0);
    run_load(0, 1'b0);
    n_vec++;
    if (wr_q.size() != 0) begin
      n_err++; $display("FAIL zero_nwr got %0d exp 0", wr_q.size());
    end
    n_vec++;
    if ({bus.done_o, bus.err_o} !== 2'b10 || bus.words_written_o !== 16'd0 || busy_cyc != 4) begin
      n_err++; $display("FAIL zero_status got done=%b err=%b ww=%0d cyc=%0d exp 1/0/0/4",
        bus.done_o, bus.err_o, bus.words_written_o, busy_cyc);
    end
  endtask

  task automatic test_overflow;
    wr_q = {};
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    n_vec++;
    if ({bus.err_o, bus.done_o, bus.byte_ready_o} !== 3'b100) begin
      n_err++; $display("FAIL ovf_err got err=%b done=%b rdy=%b exp 1/0/0",
        bus.err_o, bus.done_o, bus.byte_ready_o);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.busy_o, bus.byte_ready_o, bus.err_o} !== 3'b001) begin
      n_err++; $display("FAIL ovf_idle got busy=%b rdy=%b err=%b exp 0/0/1",
        bus.busy_o, bus.byte_ready_o, bus.err_o);
    end
    n_vec++;
    if (wr_q.size() != 0 || bus.words_written_o !== 16'd0) begin
      n_err++; $display("FAIL ovf_nwr got %0d/%0d exp 0/0", wr_q.size(), bus.words_written_o);
    end
  endtask

  task automatic test_bad_csum;
    wq = {32'hDEAD_BEEF};
    build(16'd1, 1'b0);
    stim_q[stim_q.size()-1] = 8'h00;
    exp_ok = 1'b0;
    run_load(0, 1'b0);
    n_vec++;
    if (wr_q.size() != 1) begin
      n_err++; $display("FAIL badcs_nwr got %0d exp 1", wr_q.size());
    end else begin
      n_vec++;
      if (wr_q[0] !== exp_q[0]) begin
        n_err++; $display("FAIL badcs_wr got %h exp %h", wr_q[0], exp_q[0]);
      end
    end
    n_vec++;
    if ({bus.done_o, bus.err_o} !== {exp_ok, !exp_ok}) begin
      n_err++; $display("FAIL badcs_status got done=%b err=%b exp 0/1", bus.done_o, bus.err_o);
    end
  endtask

  task automatic test_max_len;
    wq = {};
    for (int i = 0; i < 512; i++) wq.push_back($urandom);
    build(16'd512, 1'b0);
    run_load(0, 1'b0);
    n_vec++;
    if (wr_q.size() != 512) begin
      n_err++; $display("FAIL max_nwr got %0d exp 512", wr_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (wr_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL max_wr[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if ({bus.done_o, bus.err_o} !== 2'b10 || bus.words_written_o !== 16'd512) begin
      n_err++; $display("FAIL max_status got done=%b err=%b ww=%0d exp 1/0/512",
        bus.done_o, bus.err_o, bus.words_written_o);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.byte_ready_o, bus.wr_en_imem_ram_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 ||
        bus.addr_imem_ram_o !== BASE || bus.words_written_o !== 16'd0 || bus.wr_instr_imem_ram_o !== 32'h0) begin
      n_err++; $display("FAIL midrst_outputs got flags=%b addr=%h ww=%0d wd=%h exp 00000/%h/0/0",
        {bus.byte_ready_o, bus.wr_en_imem_ram_o, bus.busy_o, bus.done_o, bus.err_o},
        bus.addr_imem_ram_o, bus.words_written_o, bus.wr_instr_imem_ram_o, BASE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wq = {$urandom, $urandom};
    build(16'd2, 1'b0);
    run_load(0, 1'b0);
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL midrst_nwr got %0d exp %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_vec++;
      if (wr_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midrst_wr[%0d] got %h exp %h", i, wr_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if ({bus.done_o, bus.err_o} !== 2'b10) begin
      n_err++; $display("FAIL midrst_status got done=%b err=%b exp 1/0", bus.done_o, bus.err_o);
    end
  endtask

  task automatic test_backpressure;
    int cnt;
    bit bad;
    for (int it = 0; it < 8; it++) begin
      cnt = (it == 0) ? 4 : int'($urandom_range(1, 6));
      bad = (it != 0) && ($urandom_range(0, 3) == 0);
      wq = {};
      for (int i = 0; i < cnt; i++) wq.push_back($urandom);
      build(16'(cnt), bad);
      run_load(3, 1'b1);
      n_vec++;
      if (wr_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL bp%0d_nwr got %0d exp %0d", it, wr_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_vec++;
        if (wr_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL bp%0d_wr[%0d] got %h exp %h", it, i, wr_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if ({bus.done_o, bus.err_o} !== {exp_ok, !exp_ok} || bus.words_written_o !== 16'(cnt)) begin
        n_err++; $display("FAIL bp%0d_status got done=%b err=%b ww=%0d exp %b/%b/%0d",
          it, bus.done_o, bus.err_o, bus.words_written_o, exp_ok, !exp_ok, cnt);
      end
      n_vec++;
      if (viol != 0) begin
        n_err++; $display("FAIL bp%0d_ready got %0d violations exp 0", it, viol);
      end
    end
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    test_reset;
    test_normal;
    test_zero_len;
    test_overflow;
    test_bad_csum;
    test_max_len;
    test_reset_mid;
    test_backpressure;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
